// File: rtl/adder_3bit_arbiter.sv
// ----------------------------------------------------------------------------
// adder_3bit_arbiter : round-robin arbiter sharing one adder_3bit between two
//                      requesters, with a registered grant/done handshake.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_3bit (
    input  logic a2,
    input  logic a1,
    input  logic a0,
    input  logic b2,
    input  logic b1,
    input  logic b0,
    output logic s2,
    output logic s1,
    output logic s0,
    output logic cout
);
    logic c0;
    logic c1;

    assign s0   = a0 ^ b0;
    assign c0   = a0 & b0;
    assign s1   = a1 ^ b1 ^ c0;
    assign c1   = (a1 & b1) | (c0 & (a1 ^ b1));
    assign s2   = a2 ^ b2 ^ c1;
    assign cout = (a2 & b2) | (c1 & (a2 ^ b2));
endmodule

module adder_3bit_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [2:0] a0_in,
    input  logic [2:0] b0_in,
    input  logic       req1,
    input  logic [2:0] a1_in,
    input  logic [2:0] b1_in,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [2:0] sum,
    output logic       cout
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] opa_q, opa_d;
    logic [2:0] opb_q, opb_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done_q, done_d;
    logic       done_id_q, done_id_d;
    logic [2:0] sum_q, sum_d;
    logic       cout_q, cout_d;

    logic [2:0] add_s;
    logic       add_c;
    logic       pick_valid;
    logic       pick;

    adder_3bit u_adder (
        .a2   (opa_q[2]),
        .a1   (opa_q[1]),
        .a0   (opa_q[0]),
        .b2   (opb_q[2]),
        .b1   (opb_q[1]),
        .b0   (opb_q[0]),
        .s2   (add_s[2]),
        .s1   (add_s[1]),
        .s0   (add_s[0]),
        .cout (add_c)
    );

    // On a tie the requester not served most recently wins.
    assign pick_valid = req0 | req1;
    assign pick       = (req0 & req1) ? ~last_q : req1;

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    opa_d   = pick ? a1_in : a0_in;
                    opb_d   = pick ? b1_in : b0_in;
                    owner_d = pick;
                    last_d  = pick;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d     = add_s;
                cout_d    = add_c;
                done_id_d = owner_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opa_q     <= 3'd0;
            opb_q     <= 3'd0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= 3'd0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = (state_q == CALC);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
endmodule

`default_nettype wire
